// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused for every bit position,
// LSB first, with the inter-bit carry held in a register between clocks.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last sum
// SHIFT | one bit pair per clock through the full adder, LSB first
// DONE  | single cycle with the result valid, then back to IDLE
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_co;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .ci  (carry),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sum_sr is deliberately not cleared on load so the previous result stays visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign sum_out = sum_sr;
    assign cout    = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for timing/protocol cases
// and a 2-bit instance swept over every operand combination.

module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum_out;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .a_in    (a2),
        .b_in    (b2),
        .cin     (cin2),
        .busy    (busy2),
        .done    (done2),
        .sum_out (sum2),
        .cout    (cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an addition at the next edge (k), walk it through SHIFT and DONE.
    // With ign set, start is re-pulsed with other operands at k+3, k+8 and k+9.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit ign);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {8'b0, c};
        a_in = a; b_in = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0; a_in = ~a; b_in = b ^ 8'h5A; cin = ~c;
        for (int n = 1; n <= 8; n++) begin
            chk("busy_shift", {31'b0, busy}, 32'd1);
            chk("done_early", {31'b0, done}, 32'd0);
            if (ign && (n == 3 || n == 8)) begin
                start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_in_done", {31'b0, busy}, 32'd0);
        chk("sum", {24'b0, sum_out}, {24'b0, exp[7:0]});
        chk("cout", {31'b0, cout}, {31'b0, exp[8]});
        start = ign;
        tick();
        start = 1'b0;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("sum_held", {24'b0, sum_out}, {24'b0, exp[7:0]});
        if (ign) begin
            tick();
            chk("busy_ignored", {31'b0, busy}, 32'd0);
            chk("sum_still_held", {23'b0, cout, sum_out}, {23'b0, exp});
        end
    endtask

    logic [8:0] exp_q [3];

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", {24'b0, sum_out}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        tick();
        rst = 1'b0;

        add8(8'h5A, 8'h3C, 1'b0, 1'b0);   // 0x96
        add8(8'hFF, 8'h01, 1'b0, 1'b0);   // 0x00 carry 1
        add8(8'hFF, 8'hFF, 1'b1, 1'b0);   // 0xFF carry 1
        add8(8'h10, 8'h20, 1'b0, 1'b1);   // 0x30, extra starts ignored

        // reset in the middle of SHIFT
        a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_sum", {24'b0, sum_out}, 32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("abort_no_done", {31'b0, done}, 32'd0);
        end
        rst = 1'b0;
        add8(8'h01, 8'h01, 1'b1, 1'b0);   // 0x03

        // reset during the DONE cycle cuts the pulse
        a_in = 8'h81; b_in = 8'h81; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        chk("done_before_rst", {31'b0, done}, 32'd1);
        chk("sum_before_rst", {23'b0, cout, sum_out}, 32'h102);
        rst = 1'b1;
        #1;
        chk("done_cut", {31'b0, done}, 32'd0);
        chk("sum_cut", {23'b0, cout, sum_out}, 32'd0);
        tick();
        rst = 1'b0;

        // start held high, operands change each cycle; accepts at j = 0, 10, 20
        start = 1'b1;
        for (int j = 0; j < 30; j++) begin
            logic [7:0] ja;
            logic [7:0] jb;
            logic       jc;
            ja = 8'(j * 7 + 3);
            jb = 8'(j * 13 + 5);
            jc = 1'((j >> 1) & 1);
            a_in = ja; b_in = jb; cin = jc;
            if (j % 10 == 0) exp_q[j / 10] = {1'b0, ja} + {1'b0, jb} + {8'b0, jc};
            tick();
            if (j % 10 == 8) begin
                chk("cont_done", {31'b0, done}, 32'd1);
                chk("cont_result", {23'b0, cout, sum_out}, {23'b0, exp_q[j / 10]});
            end else begin
                chk("cont_no_done", {31'b0, done}, 32'd0);
            end
            if (j % 10 == 9) begin
                chk("cont_idle", {31'b0, busy}, 32'd0);
                chk("cont_held", {23'b0, cout, sum_out}, {23'b0, exp_q[j / 10]});
            end
        end
        start = 1'b0;
        tick();
        tick();

        // WIDTH=2 exhaustive
        for (int i = 0; i < 32; i++) begin
            logic [2:0] e2;
            a2 = 2'(i >> 3); b2 = 2'(i >> 1); cin2 = 1'(i);
            e2 = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
            start2 = 1'b1;
            tick();
            start2 = 1'b0; a2 = ~a2; b2 = ~b2;
            tick();
            chk("w2_mid", {30'b0, busy2, done2}, 32'd2);
            tick();
            chk("w2_done", {31'b0, done2}, 32'd1);
            chk("w2_result", {29'b0, cout2, sum2}, {29'b0, e2});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
